hsb_avst_axis_downsizer: RTL
============================

HSB_AVST_AXIS_DOWNSIZER -- requirements
Module: hsb_avst_axis_downsizer

Interface
REQ-001 SHALL have parameter C_BYTE_SWAP, default 1: 1 = first Avalon symbol placed in AXIS byte lane 0; 0 = raw slice, no reorder.
REQ-002 SHALL have parameter C_AV_DATA_WIDTH, default 64: Avalon data bits, a multiple of 8*C_RATIO.
REQ-003 SHALL have parameter C_RATIO, default 2: AXIS beats per Avalon beat, >=1.
REQ-004 SHALL have parameter C_AV_EMPTY_WIDTH, default 3: width of the empty field, >= clog2(C_AV_DATA_WIDTH/8).
REQ-005 SHALL have parameter C_AXIS_TUSER_WIDTH, default 1: tuser width; bit 0 carries SOP, upper bits drive 0.
REQ-006 SHALL derive AXW = C_AV_DATA_WIDTH/C_RATIO, AXB = AXW/8 and AVB = C_AV_DATA_WIDTH/8 as localparams.
REQ-007 SHALL have ports clk (in, 1, clock) and reset (in, 1); one clock, reset is asynchronous and active-high.
REQ-008 SHALL have ports av_sink_startofpacket, av_sink_endofpacket and av_sink_valid (in, 1 each), and av_sink_ready (out, 1).
REQ-009 SHALL have av_sink_data (in, C_AV_DATA_WIDTH) and av_sink_empty (in, C_AV_EMPTY_WIDTH); Avalon symbol 0 occupies the MSBs.
REQ-010 SHALL have m_axis_tdata (out, AXW), m_axis_tkeep (out, AXB), m_axis_tuser (out, C_AXIS_TUSER_WIDTH), m_axis_tlast, m_axis_tvalid (out, 1 each) and m_axis_tready (in, 1).
REQ-011 SHALL have proto_err (out, 1): a sticky protocol-violation flag.

Function
REQ-012 SHALL hold one Avalon beat in a holding register plus a beat index k (0..C_RATIO-1) and a beat count n (1..C_RATIO).
REQ-013 SHALL capture a beat on av_sink_valid && av_sink_ready, setting k=0 and tvalid=1 on the next edge (latency 1 cycle).
REQ-014 SHALL drive av_sink_ready = !m_axis_tvalid || (m_axis_tready && k==n-1), giving zero-bubble throughput.
REQ-015 SHALL, for beat k with C_BYTE_SWAP=1, drive tdata lane j = Avalon symbol k*AXB+j.
REQ-016 SHALL, for beat k with C_BYTE_SWAP=0, drive tdata = held_data[(C_RATIO-1-k)*AXW +: AXW].
REQ-017 SHALL set n = C_RATIO for non-EOP beats and ignore empty on those beats.
REQ-018 SHALL, on an EOP beat, set V = AVB-empty and n = ceil(V/AXB); beats k>=n are skipped.
REQ-019 SHALL clamp V to 1 when empty >= AVB.
REQ-020 SHALL drive tkeep all-ones except on an EOP beat with k==n-1, where r = V-(n-1)*AXB bytes are valid.
REQ-021 SHALL place those r valid keep bits in the low lanes when C_BYTE_SWAP=1 and the high lanes when C_BYTE_SWAP=0; data in invalid lanes is don't-care.
REQ-022 SHALL assert tlast only on beat k==n-1 of an EOP beat, and tuser[0] only on beat k==0 of an SOP beat.
REQ-023 SHALL advance k on tvalid && tready while k<n-1; at k==n-1 it SHALL load the next beat if one is accepted, else clear tvalid.
REQ-024 SHALL hold tdata, tkeep, tuser and tlast stable while tvalid && !tready.
REQ-025 SHALL run packet FSM IDLE/INPKT on accepted beats: SOP -> INPKT, EOP -> IDLE, SOP+EOP -> IDLE.
REQ-026 SHALL set proto_err when a beat without SOP is accepted in IDLE or a beat with SOP is accepted in INPKT.
REQ-027 SHALL, on such a violation, still forward the beat with its own SOP/EOP and apply the FSM transition of REQ-025.
REQ-028 SHALL behave with C_RATIO=1 as a one-stage registered passthrough with tkeep derived from empty.

Reset
REQ-029 SHALL, while reset is high, force m_axis_tvalid=0, tlast=0, tuser=0, tkeep=0, k=0, FSM=IDLE, proto_err=0 and av_sink_ready=0.
REQ-030 SHALL drive av_sink_ready=1 on the first clock edge after reset deasserts.
REQ-031 SHALL discard a held beat or partial packet on reset mid-packet and emit no output until a new beat is accepted.

Verification (defaults C_AV_DATA_WIDTH=64, C_RATIO=2, swap=1)
REQ-032 SHALL cover: data 0x0011223344556677, SOP+EOP, empty=0, tready=1 -> beat0 0x33221100 tkeep F tuser 1 tlast 0; beat1 0x77665544 tkeep F tlast 1.
REQ-033 SHALL cover: same beat with empty=5 -> one beat only, tdata[23:0]=0x221100, tkeep 0x7, tlast 1, tuser 1.
REQ-034 SHALL cover: 3-beat packet, valid held high, tready=1 -> 6 consecutive AXIS beats, av_sink_ready toggles 1,0,1,0.
REQ-035 SHALL cover: tready low 3 cycles mid-beat -> outputs stable, av_sink_ready 0, no beat lost or duplicated.
REQ-036 SHALL cover: first beat in IDLE without SOP -> proto_err=1 the next cycle, beat forwarded, flag held until reset.
REQ-037 SHALL cover: reset asserted after beat0 of a held pair -> tvalid 0 immediately, beat1 never emitted, proto_err 0.

Source files
------------

// File: rtl/hsb_avst_axis_downsizer.sv
// Avalon-ST to AXI4-Stream width downsizer: each accepted Avalon beat is replayed as
// up to C_RATIO narrower AXIS beats, trimmed on end-of-packet according to empty.
module hsb_avst_axis_downsizer #(
    parameter int C_BYTE_SWAP        = 1,
    parameter int C_AV_DATA_WIDTH    = 64,
    parameter int C_RATIO            = 2,
    parameter int C_AV_EMPTY_WIDTH   = 3,
    parameter int C_AXIS_TUSER_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          av_sink_startofpacket,
    input  logic                          av_sink_endofpacket,
    input  logic                          av_sink_valid,
    output logic                          av_sink_ready,
    input  logic [C_AV_DATA_WIDTH-1:0]    av_sink_data,
    input  logic [C_AV_EMPTY_WIDTH-1:0]   av_sink_empty,
    output logic [C_AV_DATA_WIDTH/C_RATIO-1:0]     m_axis_tdata,
    output logic [C_AV_DATA_WIDTH/C_RATIO/8-1:0]   m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          proto_err
);

    localparam int AXW = C_AV_DATA_WIDTH / C_RATIO;
    localparam int AXB = AXW / 8;
    localparam int AVB = C_AV_DATA_WIDTH / 8;
    localparam int KW  = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;
    localparam int RW  = $clog2(AXB + 1);

    typedef enum logic {IDLE, INPKT} pkt_state_t;

    logic [C_AV_DATA_WIDTH-1:0] held_data_reg;
    logic [KW-1:0]              k_reg;
    logic [KW-1:0]              last_k_reg;
    logic [RW-1:0]              rem_reg;
    logic                       sop_reg;
    logic                       eop_reg;
    logic                       tvalid_reg;
    logic                       rdy_en_reg;
    logic                       proto_err_reg;
    logic                       proto_err_next;
    pkt_state_t                 state_reg;
    pkt_state_t                 state_next;

    logic [31:0] empty_ext;
    logic [31:0] v_calc;
    logic [31:0] n_calc;
    logic        beat_last;
    logic        accept;

    logic [AXW-1:0] beat_word [C_RATIO];
    logic [AXB-1:0] keep_last;

    // Valid byte count V of the incoming beat and how many AXIS beats it needs.
    always_comb begin
        empty_ext = 32'(av_sink_empty);
        if (!av_sink_endofpacket)
            v_calc = 32'(AVB);
        else if (empty_ext >= 32'(AVB))
            v_calc = 32'd1;
        else
            v_calc = 32'(AVB) - empty_ext;
        n_calc = (v_calc + 32'(AXB) - 32'd1) / 32'(AXB);
    end

    assign beat_last     = (k_reg == last_k_reg);
    assign av_sink_ready = rdy_en_reg && (!tvalid_reg || (m_axis_tready && beat_last));
    assign accept        = av_sink_valid && av_sink_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_data_reg <= '0;
            k_reg         <= '0;
            last_k_reg    <= '0;
            rem_reg       <= '0;
            sop_reg       <= 1'b0;
            eop_reg       <= 1'b0;
            tvalid_reg    <= 1'b0;
            rdy_en_reg    <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
            if (accept) begin
                held_data_reg <= av_sink_data;
                k_reg         <= '0;
                last_k_reg    <= KW'(n_calc - 32'd1);
                rem_reg       <= RW'(v_calc - (n_calc - 32'd1) * 32'(AXB));
                sop_reg       <= av_sink_startofpacket;
                eop_reg       <= av_sink_endofpacket;
                tvalid_reg    <= 1'b1;
            end else if (tvalid_reg && m_axis_tready) begin
                if (beat_last)
                    tvalid_reg <= 1'b0;
                else
                    k_reg <= k_reg + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // Violating beats are still forwarded; only the sticky flag records them.
    always_comb begin
        state_next     = state_reg;
        proto_err_next = proto_err_reg;
        if (accept) begin
            if ((state_reg == IDLE && !av_sink_startofpacket) ||
                (state_reg == INPKT && av_sink_startofpacket))
                proto_err_next = 1'b1;
            if (av_sink_endofpacket)
                state_next = IDLE;
            else if (av_sink_startofpacket)
                state_next = INPKT;
        end
    end

    // Per-beat output words are fixed slices of the holding register; k only selects.
    for (genvar gi = 0; gi < C_RATIO; gi++) begin : g_beat
        for (genvar gj = 0; gj < AXB; gj++) begin : g_lane
            if (C_BYTE_SWAP != 0) begin : g_swap
                assign beat_word[gi][gj*8 +: 8] = held_data_reg[(AVB-1-(gi*AXB+gj))*8 +: 8];
            end else begin : g_raw
                assign beat_word[gi][gj*8 +: 8] = held_data_reg[(C_RATIO-1-gi)*AXW + gj*8 +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < AXB; gi++) begin : g_keep
        if (C_BYTE_SWAP != 0) begin : g_low
            assign keep_last[gi] = (32'(gi) < 32'(rem_reg));
        end else begin : g_high
            assign keep_last[gi] = (32'(gi) + 32'(rem_reg) >= 32'(AXB));
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = beat_word[k_reg];
    assign m_axis_tkeep  = !tvalid_reg ? '0 : ((eop_reg && beat_last) ? keep_last : '1);
    assign m_axis_tlast  = tvalid_reg && eop_reg && beat_last;
    assign m_axis_tuser  = C_AXIS_TUSER_WIDTH'(tvalid_reg && sop_reg && (k_reg == '0));
    assign proto_err     = proto_err_reg;

endmodule
